// File: rtl/mac_pkg.sv
// Shared constants and FSM encoding for the mac operand feeder and mac.
package mac_pkg;
  localparam int WIDTH_DEF   = 16;
  localparam int MAC_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;
endpackage

// File: rtl/mac.sv
// Multiply-accumulate: one registered accumulator, sync active-low clear.
module mac
  import mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // low WIDTH bits of the product are sign-agnostic
  always_comb begin
    acc_d = acc_q + A * B;
    if (!rstb) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign out = acc_q;
endmodule

// File: rtl/mac_operand_buf.sv
// Operand pair register file: one sync write, one async read, sync clear.
module mac_operand_buf
  import mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic [WIDTH-1:0] wdata_w,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_in,
  output logic [WIDTH-1:0] rdata_w
);
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = {wdata_in, wdata_w};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_in = mem_q[raddr][2*WIDTH-1:WIDTH];
  assign rdata_w  = mem_q[raddr][WIDTH-1:0];
endmodule

// File: rtl/mac_operand_feeder.sv
// Streams buffered operand pairs into a mac and returns the dot product.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = 8,
  parameter int MAC_LAT = mac_pkg::MAC_LAT_DEF,
  parameter int AW      = $clog2(DEPTH),
  parameter int LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_in,
  input  logic [WIDTH-1:0] wr_w,
  input  logic [LW-1:0]    len,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] mac_a,
  output logic [WIDTH-1:0] mac_b,
  output logic             mac_rstb,
  input  logic [WIDTH-1:0] mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mac_a_q, mac_a_d;
  logic [WIDTH-1:0] mac_b_q, mac_b_d;
  logic             mac_rstb_q, mac_rstb_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [WIDTH-1:0] rd_in, rd_w;
  logic             len_ok;

  mac_operand_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk     (clk),
    .clr     (rst),
    .we      (wr_en && (state_q == S_IDLE)),
    .waddr   (wr_addr),
    .wdata_in(wr_in),
    .wdata_w (wr_w),
    .raddr   (idx_d),
    .rdata_in(rd_in),
    .rdata_w (rd_w)
  );

  assign len_ok = (len != '0) && (len <= LW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && len_ok) begin
          len_d   = len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (LW'(idx_q) == len_q - 1'b1) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(MAC_LAT - 1)) begin
          res_data_d  = mac_out;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with it
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    mac_rstb_d = (state_d != S_CLEAR);
    mac_a_d    = '0;
    mac_b_d    = '0;
    if (state_d == S_STREAM) begin
      mac_a_d = rd_in;
      mac_b_d = rd_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_rstb_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_rstb_q  <= mac_rstb_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = busy_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_rstb  = mac_rstb_q & ~rst;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench: feeder plus mac, with a scoreboard of expected dot products.
module tb_mac_operand_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_in, wr_w;
  logic [3:0]  len;
  logic        start;
  logic        busy;
  logic [15:0] mac_a, mac_b, mac_out;
  logic        mac_rstb;
  logic        res_valid, res_ready;
  logic [15:0] res_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic signed [15:0] m_in[8];
  logic signed [15:0] m_w[8];

  always #5 clk = ~clk;

  mac_operand_feeder #(.WIDTH(16), .DEPTH(8), .MAC_LAT(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_in(wr_in), .wr_w(wr_w), .len(len), .start(start),
    .busy(busy), .mac_a(mac_a), .mac_b(mac_b), .mac_rstb(mac_rstb),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  mac #(.WIDTH(16)) u_mac (
    .clk(clk), .rstb(mac_rstb), .A(mac_a), .B(mac_b), .out(mac_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sum(input int n);
    logic [15:0] s = '0;
    for (int i = 0; i < n; i++) s = s + m_in[i] * m_w[i];
    return s;
  endfunction

  task automatic wr(input int a, input int x, input int y);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_in = 16'(x);
    wr_w = 16'(y);
    tick();
    wr_en = 1'b0;
    m_in[a] = 16'(x);
    m_w[a] = 16'(y);
  endtask

  task automatic run(input int n, input int hold, input bit mid_wr);
    int c;
    logic bz_ok;
    logic [15:0] e;
    len = 4'(n);
    start = 1'b1;
    exp_q.push_back(model_sum(n));
    tick();
    start = 1'b0;
    c = 1;
    bz_ok = 1'b1;
    chk("clear_rstb", mac_rstb, 0);
    while (!res_valid && c < 60) begin
      if (!busy) bz_ok = 1'b0;
      if (c == 2) chk("first_a", mac_a, m_in[0]);
      wr_en = (c == 3) && mid_wr;
      wr_addr = 3'd0;
      wr_in = 16'd99;
      wr_w = 16'd99;
      tick();
      c++;
    end
    wr_en = 1'b0;
    chk("latency", c, n + 3);
    chk("busy_run", bz_ok, 1);
    chk("hold_busy", busy, 1);
    chk("sb_size", exp_q.size(), 1);
    e = exp_q.pop_front();
    chk("res_data", res_data, e);
    repeat (hold) begin
      start = 1'b1;
      len = 4'd3;
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, e);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    chk("post_valid", res_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_in = '0;
    wr_w = '0;
    len = '0;
    start = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_in[i] = '0;
      m_w[i] = '0;
    end
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rstb", mac_rstb, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_a", mac_a, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rstb", mac_rstb, 1);

    wr(0, 1, 4);  wr(1, 4, -3); wr(2, 7, 2);  wr(3, -2, -1);
    wr(4, 3, 2);  wr(5, -5, 1); wr(6, 2, -5); wr(7, 3, 7);
    run(8, 0, 1'b0);
    chk("sum8", model_sum(8), 16'd20);
    run(3, 0, 1'b0);
    run(8, 0, 1'b0);
    run(8, 5, 1'b0);

    start = 1'b1;
    len = 4'd0;
    tick();
    chk("len0_busy", busy, 0);
    chk("len0_rstb", mac_rstb, 1);
    len = 4'd9;
    tick();
    chk("len9_busy", busy, 0);
    chk("len9_rstb", mac_rstb, 1);
    start = 1'b0;
    tick();

    run(8, 0, 1'b1);
    run(1, 0, 1'b0);

    len = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("idx4_a", mac_a, m_in[4]);
    rst = 1'b1;
    tick();
    chk("abort_rstb", mac_rstb, 0);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    for (int i = 0; i < 8; i++) begin
      m_in[i] = '0;
      m_w[i] = '0;
    end
    tick();
    run(8, 0, 1'b0);

    wr(0, 32767, 2);
    wr(1, 1, 1);
    run(2, 0, 1'b0);
    chk("wrap", model_sum(2), 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
